// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode renderer.
//   - Default geometry (columns, rows, glyph height) and blink period.
//   - Foreground/background colours and the 4:4:4 pixel type.
package text_pkg;

  typedef logic [11:0] rgb_t;

  localparam int unsigned TextColsDefault    = 80;
  localparam int unsigned TextRowsDefault    = 30;
  localparam int unsigned CharHeightDefault  = 16;
  localparam int unsigned BlinkFramesDefault = 30;

  localparam rgb_t RgbFg = 12'hFFF;
  localparam rgb_t RgbBg = 12'h000;

endpackage

// File: rtl/cursor_blink.sv
// Cursor blink generator.
//   clk      : pixel clock
//   rst      : asynchronous active-high reset
//   vsync_in : raw vertical sync; each rising edge counts one frame
//   blink_on : high while the cursor should be visible; toggles every
//              BLINK_FRAMES frames, starts high after reset
module cursor_blink
  import text_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = BlinkFramesDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic blink_on
);

  localparam int unsigned CntW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  logic            vsync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            blink_q, blink_d;
  logic            vsync_rise;

  always_comb begin
    vsync_rise = vsync_in & ~vsync_q;
    cnt_d      = cnt_q;
    blink_d    = blink_q;
    if (vsync_rise) begin
      // Wrap and toggle share the same edge: one increment, one toggle.
      if (cnt_q == CntW'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else begin
      vsync_q <= vsync_in;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink_on = blink_q;

endmodule

// File: rtl/text_render_ctrl.sv
// Text-mode pixel renderer: four-stage pipeline from VGA timing to colour.
//   hcount/vcount, *_in strobes : VGA timing inputs
//   vram_addr  -> vram_data     : external text buffer (data one cycle later)
//   char_address -> data_rom    : external glyph ROM (combinational)
//   cursor_col/row/en           : cursor cell and enable
//   rgb, *_out strobes          : pixel colour and strobes, 4 cycles after input
module text_render_ctrl
  import text_pkg::*;
#(
  parameter int unsigned TEXT_COLS    = TextColsDefault,
  parameter int unsigned TEXT_ROWS    = TextRowsDefault,
  parameter int unsigned CHAR_HEIGHT  = CharHeightDefault,
  parameter int unsigned BLINK_FRAMES = BlinkFramesDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  output logic [11:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic [11:0] char_address,
  input  logic [7:0]  data_rom,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic        cursor_en,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out
);

  localparam int unsigned RowShift       = $clog2(CHAR_HEIGHT);
  localparam logic [3:0]  CursorFirstRow = 4'(CHAR_HEIGHT - 2);

  logic blink_on;

  cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk     (clk),
    .rst     (rst),
    .vsync_in(vsync_in),
    .blink_on(blink_on)
  );

  // Stage 0 combinational
  logic [7:0]  col_w;
  logic [10:0] row_w;
  logic [11:0] vram_addr_d;
  logic        in_range_d, match_d;

  // Pipeline registers; sync_* is {hsync, vsync, blank}
  logic [11:0] vram_addr_q;
  logic [2:0]  pix_s0_q, pix_s1_q, pix_s2_q;
  logic [3:0]  glyph_s0_q, glyph_s1_q;
  logic        in_range_s0_q, in_range_s1_q, in_range_s2_q;
  logic        match_s0_q, match_s1_q;
  logic [2:0]  sync_s0_q, sync_s1_q, sync_s2_q;
  logic [11:0] char_address_q;
  logic [7:0]  rom_q;
  logic        hit_d, hit_s2_q;
  rgb_t        rgb_d, rgb_q;
  logic        pix_bit;
  logic        hsync_out_q, vsync_out_q, blank_out_q;

  always_comb begin
    col_w      = hcount[10:3];
    row_w      = vcount >> RowShift;
    // Widened so the multiply cannot wrap before the final 12-bit truncation.
    vram_addr_d = 12'(16'(row_w) * 16'(TEXT_COLS) + 16'(col_w));
    in_range_d = (32'(col_w) < TEXT_COLS) && (32'(row_w) < TEXT_ROWS);
    match_d    = cursor_en && (col_w == {1'b0, cursor_col}) && (row_w == {6'b0, cursor_row});
  end

  always_comb begin
    hit_d   = match_s1_q && (glyph_s1_q >= CursorFirstRow) && blink_on;
    pix_bit = rom_q[3'd7 - pix_s2_q] ^ hit_s2_q;
    if (sync_s2_q[0]) begin
      rgb_d = 12'h000;
    end else if (!in_range_s2_q) begin
      rgb_d = RgbBg;
    end else begin
      rgb_d = pix_bit ? RgbFg : RgbBg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_addr_q    <= '0;
      pix_s0_q       <= '0;
      glyph_s0_q     <= '0;
      in_range_s0_q  <= 1'b0;
      match_s0_q     <= 1'b0;
      sync_s0_q      <= '0;
      char_address_q <= '0;
      pix_s1_q       <= '0;
      glyph_s1_q     <= '0;
      in_range_s1_q  <= 1'b0;
      match_s1_q     <= 1'b0;
      sync_s1_q      <= '0;
      rom_q          <= '0;
      pix_s2_q       <= '0;
      in_range_s2_q  <= 1'b0;
      hit_s2_q       <= 1'b0;
      sync_s2_q      <= '0;
      rgb_q          <= '0;
      hsync_out_q    <= 1'b0;
      vsync_out_q    <= 1'b0;
      blank_out_q    <= 1'b1;
    end else begin
      // Stage 0: address and cell attributes
      vram_addr_q    <= vram_addr_d;
      pix_s0_q       <= hcount[2:0];
      glyph_s0_q     <= vcount[3:0];
      in_range_s0_q  <= in_range_d;
      match_s0_q     <= match_d;
      sync_s0_q      <= {hsync_in, vsync_in, blank_in};
      // Stage 1: glyph ROM address from character code
      char_address_q <= {vram_data, glyph_s0_q};
      pix_s1_q       <= pix_s0_q;
      glyph_s1_q     <= glyph_s0_q;
      in_range_s1_q  <= in_range_s0_q;
      match_s1_q     <= match_s0_q;
      sync_s1_q      <= sync_s0_q;
      // Stage 2: glyph row and cursor hit
      rom_q          <= data_rom;
      pix_s2_q       <= pix_s1_q;
      in_range_s2_q  <= in_range_s1_q;
      hit_s2_q       <= hit_d;
      sync_s2_q      <= sync_s1_q;
      // Stage 3: colour and strobes
      rgb_q          <= rgb_d;
      hsync_out_q    <= sync_s2_q[2];
      vsync_out_q    <= sync_s2_q[1];
      blank_out_q    <= sync_s2_q[0];
    end
  end

  assign vram_addr    = vram_addr_q;
  assign char_address = char_address_q;
  assign rgb          = rgb_q;
  assign hsync_out    = hsync_out_q;
  assign vsync_out    = vsync_out_q;
  assign blank_out    = blank_out_q;

endmodule

// File: tb/tb_text_render_ctrl.sv
module tb_text_render_ctrl;

  localparam int Cols = 80;
  localparam int Rows = 30;
  localparam int Ch   = 16;
  localparam int Bf   = 30;
  localparam int NRnd = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount, vcount;
  logic        hsync_in, vsync_in, blank_in;
  logic [11:0] vram_addr, char_address, rgb;
  logic [7:0]  vram_data, data_rom;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        cursor_en;
  logic        hsync_out, vsync_out, blank_out;

  logic [7:0] vram_mem [4096];
  logic [7:0] rom_mem  [4096];

  int   total = 0;
  int   bad   = 0;
  int   pulses = 0;
  bit   prev_vs = 1'b0;

  // Text buffer answers the registered address; glyph ROM is combinational.
  assign vram_data = vram_mem[vram_addr];
  assign data_rom  = rom_mem[char_address];

  text_render_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .blank_in    (blank_in),
    .vram_addr   (vram_addr),
    .vram_data   (vram_data),
    .char_address(char_address),
    .data_rom    (data_rom),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .cursor_en   (cursor_en),
    .rgb         (rgb),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .blank_out   (blank_out)
  );

  always #5 clk = ~clk;

  // Reference: colour of one screen pixel from the rendering rules.
  function automatic logic [11:0] model_rgb(int h, int v, bit blank, int ccol, int crow,
                                            bit cen, int npulses);
    int         col, row, gr;
    logic [7:0] code, glyph;
    bit         px, hit, blink;
    if (blank) return 12'h000;
    col = h / 8;
    row = v / Ch;
    gr  = v % Ch;
    if (col >= Cols || row >= Rows) return 12'h000;
    code  = vram_mem[row * Cols + col];
    glyph = rom_mem[code * 16 + gr];
    px    = glyph[7 - (h % 8)];
    blink = ((npulses / Bf) % 2) == 0;
    hit   = cen && (col == ccol) && (row == crow) && (gr >= Ch - 2) && blink;
    return (px ^ hit) ? 12'hFFF : 12'h000;
  endfunction

  task automatic set_in(int h, int v, bit b, bit hs, bit vs);
    hcount   = 11'(h);
    vcount   = 11'(v);
    blank_in = b;
    hsync_in = hs;
    vsync_in = vs;
    if (vs && !prev_vs) pulses++;
    prev_vs = vs;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 1'b0, 1'b0, 1'b0);
    pulses  = 0;
    prev_vs = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_vsync;
    @(negedge clk) set_in(0, 600, 1'b1, 1'b0, 1'b1);
    @(negedge clk) set_in(0, 600, 1'b1, 1'b0, 1'b1);
    @(negedge clk) set_in(0, 600, 1'b1, 1'b0, 1'b0);
    @(negedge clk) set_in(0, 600, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_in(0, 0, 1'b0, 1'b1, 1'b0);
    cursor_col = '0; cursor_row = '0; cursor_en = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (vram_addr !== 12'd0) begin bad++; $display("FAIL reset vram_addr: got %h want 000", vram_addr); end
    total++; if (char_address !== 12'd0) begin bad++; $display("FAIL reset char_address: got %h want 000", char_address); end
    total++; if (rgb !== 12'd0) begin bad++; $display("FAIL reset rgb: got %h want 000", rgb); end
    total++; if (hsync_out !== 1'b0) begin bad++; $display("FAIL reset hsync_out: got %b want 0", hsync_out); end
    total++; if (vsync_out !== 1'b0) begin bad++; $display("FAIL reset vsync_out: got %b want 0", vsync_out); end
    total++; if (blank_out !== 1'b1) begin bad++; $display("FAIL reset blank_out: got %b want 1", blank_out); end
    total++; if (dut.u_blink.blink_on !== 1'b1) begin bad++; $display("FAIL reset blink_on: got %b want 1", dut.u_blink.blink_on); end
  endtask

  task automatic test_first_pixel;
    logic [11:0] exp;
    cursor_en = 1'b0;
    do_reset();  // h=0, v=0 already applied at release
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        exp = (i == 4) ? 12'hFFF : 12'h000;
        total++;
        if (rgb !== exp) begin bad++; $display("FAIL first_pixel h=%0d: got %h want %h", i - 4, rgb, exp); end
      end
      if (i < 8) set_in(i, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_addr_boundary;
    logic [11:0] exp_rgb;
    logic [11:0] exp_ca;
    cursor_en = 1'b0;
    @(negedge clk) set_in(639, 479, 1'b0, 1'b0, 1'b0);
    exp_rgb = model_rgb(639, 479, 1'b0, 0, 0, 1'b0, pulses);
    exp_ca  = {vram_mem[29 * 80 + 79], 4'hF};
    @(negedge clk);
    total++; if (vram_addr !== 12'd2399) begin bad++; $display("FAIL addr_boundary vram_addr: got %0d want 2399", vram_addr); end
    @(negedge clk);
    total++; if (char_address !== exp_ca) begin bad++; $display("FAIL addr_boundary char_address: got %h want %h", char_address, exp_ca); end
    repeat (2) @(negedge clk);
    total++; if (rgb !== exp_rgb) begin bad++; $display("FAIL addr_boundary rgb: got %h want %h", rgb, exp_rgb); end
  endtask

  task automatic test_blank_strobes;
    logic [11:0] exp_rgb [16];
    bit          e_hs [16], e_vs [16], e_b [16];
    int          h;
    bit          b, hs, vs;
    cursor_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        total++; if (rgb !== exp_rgb[i-4]) begin bad++; $display("FAIL blank_strobes rgb step%0d: got %h want %h", i - 4, rgb, exp_rgb[i-4]); end
        total++; if ({hsync_out, vsync_out, blank_out} !== {e_hs[i-4], e_vs[i-4], e_b[i-4]}) begin
          bad++; $display("FAIL blank_strobes strobes step%0d: got %b%b%b want %b%b%b", i - 4,
                          hsync_out, vsync_out, blank_out, e_hs[i-4], e_vs[i-4], e_b[i-4]);
        end
      end
      if (i < 16) begin
        case (i)
          0:       begin h = 648; b = 1'b0; hs = 1'b0; vs = 1'b0; end
          1:       begin h = 648; b = 1'b1; hs = 1'b1; vs = 1'b0; end
          2:       begin h = 0;   b = 1'b0; hs = 1'b0; vs = 1'b1; end
          3:       begin h = 0;   b = 1'b1; hs = 1'b1; vs = 1'b1; end
          default: begin
            h = 0; b = 1'($urandom_range(0, 1)); hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
          end
        endcase
        set_in(h, 0, b, hs, vs);
        e_hs[i] = hs; e_vs[i] = vs; e_b[i] = b;
        case (i)
          0, 1, 3: exp_rgb[i] = 12'h000;
          2:       exp_rgb[i] = 12'hFFF;
          default: exp_rgb[i] = model_rgb(h, 0, b, 0, 0, 1'b0, pulses);
        endcase
      end
    end
  endtask

  task automatic test_cursor;
    logic [11:0] exp;
    do_reset();
    cursor_col = 7'd5; cursor_row = 5'd2; cursor_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        exp = (i - 4 < 8) ? 12'hFFF : 12'h000;
        total++; if (rgb !== exp) begin bad++; $display("FAIL cursor step%0d: got %h want %h", i - 4, rgb, exp); end
      end
      if (i < 8)       set_in(40 + i, 46, 1'b0, 1'b0, 1'b0);
      else if (i < 16) set_in(32 + i, 45, 1'b0, 1'b0, 1'b0);
      else if (i < 20) set_in(48 + i - 16, 46, 1'b0, 1'b0, 1'b0);  // neighbouring cell
    end
  endtask

  task automatic test_blink;
    logic [11:0] exp;
    do_reset();
    cursor_col = 7'd5; cursor_row = 5'd2; cursor_en = 1'b1;
    for (int p = 1; p <= 60; p++) begin
      pulse_vsync();
      @(negedge clk) set_in(40, 46, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      exp = ((p / 30) % 2 == 0) ? 12'hFFF : 12'h000;
      total++; if (rgb !== exp) begin bad++; $display("FAIL blink pulse%0d rgb: got %h want %h", p, rgb, exp); end
      if (p == 30 || p == 60) begin
        total++;
        if (dut.u_blink.blink_on !== (p == 60)) begin
          bad++; $display("FAIL blink pulse%0d blink_on: got %b want %b", p, dut.u_blink.blink_on, p == 60);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [11:0] exp_rgb [NRnd];
    bit          e_hs [NRnd], e_b [NRnd];
    int          cc, cr, h, v;
    bit          cen, b, hs;
    do_reset();
    cc = 0; cr = 0; cen = 1'b0;
    for (int i = 0; i < NRnd + 4; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        total++; if (rgb !== exp_rgb[i-4]) begin bad++; $display("FAIL random rgb step%0d: got %h want %h", i - 4, rgb, exp_rgb[i-4]); end
        total++; if ({hsync_out, vsync_out, blank_out} !== {e_hs[i-4], 1'b0, e_b[i-4]}) begin
          bad++; $display("FAIL random strobes step%0d: got %b%b%b want %b0%b", i - 4,
                          hsync_out, vsync_out, blank_out, e_hs[i-4], e_b[i-4]);
        end
      end
      if (i < NRnd) begin
        // Cursor moves mid-line; the model uses the value present at entry.
        if (i % 16 == 0 || i % 16 == 9) begin
          cc  = $urandom_range(0, 79);
          cr  = $urandom_range(0, 29);
          cen = ($urandom_range(0, 3) != 0);
          cursor_col = 7'(cc); cursor_row = 5'(cr); cursor_en = cen;
        end
        if ($urandom_range(0, 1) == 1) begin
          h = cc * 8 + $urandom_range(0, 7);
          v = cr * 16 + $urandom_range(10, 15);
        end else begin
          h = $urandom_range(0, 799);
          v = $urandom_range(0, 524);
        end
        b  = ($urandom_range(0, 7) == 0);
        hs = 1'($urandom_range(0, 1));
        set_in(h, v, b, hs, 1'b0);
        exp_rgb[i] = model_rgb(h, v, b, cc, cr, cen, pulses);
        e_hs[i] = hs; e_b[i] = b;
      end
    end
  endtask

  task automatic test_midline_reset;
    do_reset();
    cursor_en = 1'b0;
    repeat (30) pulse_vsync();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) set_in(0, 0, 1'b0, 1'b1, 1'b1);
      else       set_in(639, 479, 1'b0, 1'b1, 1'b1);
    end
    @(negedge clk);
    total++; if (rgb !== 12'hFFF) begin bad++; $display("FAIL midline pre rgb: got %h want fff", rgb); end
    total++; if (vram_addr !== 12'd2399) begin bad++; $display("FAIL midline pre vram_addr: got %0d want 2399", vram_addr); end
    total++; if (dut.u_blink.blink_on !== 1'b0) begin bad++; $display("FAIL midline pre blink_on: got %b want 0", dut.u_blink.blink_on); end
    #2 rst = 1'b1;
    #1;
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL midline rgb: got %h want 000", rgb); end
    total++; if (vram_addr !== 12'd0) begin bad++; $display("FAIL midline vram_addr: got %h want 000", vram_addr); end
    total++; if (char_address !== 12'd0) begin bad++; $display("FAIL midline char_address: got %h want 000", char_address); end
    total++; if ({hsync_out, vsync_out, blank_out} !== 3'b001) begin
      bad++; $display("FAIL midline strobes: got %b%b%b want 001", hsync_out, vsync_out, blank_out);
    end
    total++; if (dut.u_blink.blink_on !== 1'b1) begin bad++; $display("FAIL midline blink_on: got %b want 1", dut.u_blink.blink_on); end
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      vram_mem[a] = 8'($urandom);
      rom_mem[a]  = 8'($urandom);
    end
    vram_mem[0] = 8'h41;
    rom_mem[{8'h41, 4'h0}] = 8'h80;
    vram_mem[2 * 80 + 5] = 8'h00;
    vram_mem[2 * 80 + 6] = 8'h00;
    for (int g = 0; g < 16; g++) rom_mem[g] = 8'h00;

    test_reset();
    test_first_pixel();
    test_addr_boundary();
    test_blank_strobes();
    test_cursor();
    test_blink();
    test_random();
    test_midline_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_render_ctrl.md
TEXT_RENDER_CTRL -- requirements
Module: text_render_ctrl

Interface
REQ-001 The module SHALL have parameter TEXT_COLS, default 80, meaning character columns per line.
REQ-002 The module SHALL have parameter TEXT_ROWS, default 30, meaning character lines per screen.
REQ-003 The module SHALL have parameter CHAR_HEIGHT, default 16, meaning glyph rows per character (power of two).
REQ-004 The module SHALL have parameter BLINK_FRAMES, default 30, meaning frames per cursor blink half-period.
REQ-005 The module SHALL have port clk, input, 1, the pixel clock; one clock only.
REQ-006 The module SHALL have port rst, input, 1, with asynchronous active-high reset.
REQ-007 The module SHALL have port hcount, input, 11, the pixel x from VGA timing.
REQ-008 The module SHALL have port vcount, input, 11, the pixel y from VGA timing.
REQ-009 The module SHALL have ports hsync_in, vsync_in and blank_in, input, 1 each, the timing strobes aligned with hcount/vcount.
REQ-010 The module SHALL have port vram_addr, output, 12, the text buffer address.
REQ-011 The module SHALL have port vram_data, input, 8, the character code, valid one cycle after vram_addr.
REQ-012 The module SHALL have port char_address, output, 12, the glyph ROM address.
REQ-013 The module SHALL have port data_rom, input, 8, the glyph row, combinational from char_address.
REQ-014 The module SHALL have ports cursor_col (7 bits), cursor_row (5 bits) and cursor_en (1 bit), all input, giving the cursor position and enable.
REQ-015 The module SHALL have port rgb, output, 12, the 4:4:4 pixel colour.
REQ-016 The module SHALL have ports hsync_out, vsync_out and blank_out, output, 1 each, the strobes delayed to match rgb.

Function
REQ-017 Stage 0 SHALL register vram_addr = (vcount/CHAR_HEIGHT)*TEXT_COLS + hcount/8, computed in 12 bits without overflow.
REQ-018 Stage 1 SHALL register char_address = {vram_data, glyph_row}, where glyph_row = vcount[3:0] delayed one cycle.
REQ-019 Stage 2 SHALL register data_rom together with the delayed hcount[2:0], in-range flag, cursor-hit flag and strobes.
REQ-020 Stage 3 SHALL register rgb and the strobes; total latency from hcount/vcount to rgb SHALL be exactly 4 cycles, and the strobes SHALL see the same 4 cycles.
REQ-021 Pixel bit SHALL be data_rom[7 - hcount[2:0]], so the MSB is the leftmost pixel.
REQ-022 rgb SHALL be FG (12'hFFF) when the bit is 1, otherwise BG (12'h000).
REQ-023 When blank is high at stage 3, rgb SHALL be 12'h000.
REQ-024 When the column is >= TEXT_COLS or the row is >= TEXT_ROWS, rgb SHALL be BG, and vram_addr SHALL still be driven but its data ignored.
REQ-025 A cursor hit SHALL occur when cursor_en=1, the cell equals (cursor_col, cursor_row), glyph_row >= CHAR_HEIGHT-2, and blink_on=1; a hit SHALL invert the pixel bit.
REQ-026 The blink counter SHALL increment on each vsync_in rising edge, detected with a registered previous value.
REQ-027 When the counter reaches BLINK_FRAMES-1, the next edge SHALL wrap it to 0 and toggle blink_on.
REQ-028 cursor_col, cursor_row and cursor_en SHALL be sampled at stage 0 and carried down the pipeline; a mid-line change SHALL affect only pixels entering after the change.
REQ-029 When a vsync edge and a counter wrap coincide, the block SHALL apply exactly one increment and one toggle.

Reset
REQ-030 On rst, all pipeline registers, vram_addr, char_address and rgb SHALL clear to 0.
REQ-031 On rst, hsync_out, vsync_out and blank_out SHALL clear to 0, 0 and 1 respectively.
REQ-032 On rst, the blink counter SHALL clear to 0, blink_on SHALL set to 1, and the previous-vsync register SHALL clear to 0.
REQ-033 A reset asserted mid-frame SHALL take effect immediately, with no glitch gating required.
REQ-034 Output SHALL be valid from the 4th clock after rst deasserts.

Structure
REQ-035 The shared package text_pkg SHALL hold the TEXT_COLS/TEXT_ROWS/CHAR_HEIGHT defaults, the FG/BG constants, and the typedef rgb_t (logic [11:0]).
REQ-036 The blink counter and vsync edge detect SHALL form one sub-module, cursor_blink (ports clk, rst, vsync_in, blink_on).
REQ-037 char_rom and the text buffer SHALL stay external and be connected through ports.

Verification
REQ-038 Reset release with vram_data=8'h41 and data_rom=8'h80 at hcount=0, vcount=0: rgb SHALL be 12'hFFF at cycle 4 and 12'h000 for hcount=1..7.
REQ-039 hcount=639, vcount=479: vram_addr SHALL be 2399, and char_address SHALL be {vram_data, 4'hF} one cycle later.
REQ-040 hcount=648 with blank_in=0: rgb SHALL be BG; with blank_in=1, rgb SHALL be 0, and strobes SHALL be delayed exactly 4 cycles.
REQ-041 cursor (5,2), cursor_en=1, vcount=46, data_rom=0: the cell pixels SHALL be 12'hFFF; at vcount=45 they SHALL be 12'h000.
REQ-042 60 vsync pulses: blink_on SHALL go low after pulse 30 and high after pulse 60, and cursor pixels SHALL follow.
REQ-043 rst pulsed mid-line: all outputs SHALL go to reset values within the same cycle, and blink_on SHALL be 1.
